btb_predictor: RTL and testbench
================================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the PC and target width in bits.
REQ-002 The block SHALL have parameter ENTRIES, default 16, giving the number of direct-mapped entries; the value is a power of two, 2..256.
REQ-003 The block SHALL have parameter IDX_W, default log2(ENTRIES), giving the index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port lookup_pc, input, ADDR_W bits: the IF-stage PC to predict.
REQ-007 The block SHALL have port pred_hit, output, 1 bit: a valid entry matches lookup_pc.
REQ-008 The block SHALL have port pred_taken, output, 1 bit: predicted taken.
REQ-009 The block SHALL have port pred_target, output, ADDR_W bits: the predicted next PC.
REQ-010 The block SHALL have port upd_valid, input, 1 bit: an update from the resolving (EXE) stage is present this cycle.
REQ-011 The block SHALL have port upd_pc, input, ADDR_W bits: the PC of the resolved branch or jump.
REQ-012 The block SHALL have port upd_taken, input, 1 bit: the actual outcome.
REQ-013 The block SHALL have port upd_target, input, ADDR_W bits: the actual taken target.
REQ-014 The block SHALL have port upd_jump, input, 1 bit: the resolved instruction is an unconditional j/jal/jr.
REQ-015 The block SHALL have port flush_all, input, 1 bit: invalidate every entry.

Function
REQ-016 Index SHALL be lookup_pc[IDX_W+1:2]; tag SHALL be lookup_pc[ADDR_W-1:IDX_W+2]; PC bits [1:0] are ignored.
REQ-017 Each entry SHALL hold valid, tag, target (ADDR_W) and a 2-bit saturating counter ctr.
REQ-018 Lookup SHALL be combinational, with zero-cycle latency from lookup_pc to the pred_* outputs.
REQ-019 pred_hit SHALL equal valid & (stored tag == lookup tag).
REQ-020 pred_taken SHALL equal pred_hit & ctr[1].
REQ-021 pred_target SHALL equal the stored target when pred_taken is 1, and lookup_pc+4 (modulo 2^ADDR_W) otherwise.
REQ-022 An update on a tag hit SHALL increment ctr (saturating at 3) when upd_taken is 1 and decrement it (saturating at 0) otherwise.
REQ-023 An update on a tag hit SHALL overwrite the target with upd_target only when upd_taken is 1.
REQ-024 An update on a miss (invalid entry or tag mismatch) with upd_taken=1 SHALL allocate or replace the entry: valid=1, new tag, target=upd_target, ctr=2'b10.
REQ-025 An update on a miss with upd_taken=0 SHALL leave the entry unchanged (no allocation).
REQ-026 upd_jump=1 SHALL force ctr=2'b11 and write the target regardless of the prior state; upd_taken is treated as 1.
REQ-027 Updates SHALL take effect at the rising edge; a lookup of the same index in the same cycle returns the pre-update contents (no bypass).
REQ-028 flush_all=1 SHALL clear all valid bits at the edge; counters and targets are retained but unobservable.
REQ-029 flush_all and upd_valid in the same cycle SHALL result in flush winning: no entry valid afterwards.
REQ-030 Updates with upd_valid=0 SHALL be ignored entirely.

Reset
REQ-031 Asserting reset SHALL clear all valid bits immediately, set all ctr to 2'b01 and all targets/tags to 0.
REQ-032 During and after reset the outputs SHALL be pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
REQ-033 An update coincident with reset assertion SHALL be discarded; reset asserted mid-operation overrides any pending update.

Configuration
REQ-034 With macro BTB_PERF_CNT_EN defined, the block SHALL add 32-bit outputs upd_cnt and mispred_cnt, reset to 0 and wrapping at 2^32.
REQ-035 With BTB_PERF_CNT_EN defined, upd_cnt SHALL increment on every accepted update; mispred_cnt SHALL increment when the pre-update prediction for upd_pc (pred_taken, or its target when taken) differs from the actual outcome/target.
REQ-036 Without BTB_PERF_CNT_EN, those ports and counters SHALL be absent, with no other behavioural change.

Verification
REQ-037 Reset, then lookup_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044.
REQ-038 Update pc=0x40 taken target=0x100, then lookup 0x40 -> hit=1, taken=1 (ctr=2), target=0x100; two not-taken updates -> ctr=0, pred_target=0x44.
REQ-039 ENTRIES=16: allocate 0x40 and then 0x80 (same index, different tag) -> lookup 0x40 misses and 0x80 hits.
REQ-040 Jump update pc=0x200 target=0x3000 -> ctr=3; one not-taken update -> ctr=2, still predicts 0x3000.
REQ-041 flush_all and upd_valid in the same cycle, then reset pulse mid-stream -> all lookups miss and counters (if BTB_PERF_CNT_EN) read 0.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters; optional perf counters under BTB_PERF_CNT_EN.
// Latency: lookup is combinational (zero cycles); updates and flushes land at the next rising clk edge.
// Backpressure: none; an update is accepted every cycle upd_valid is high, and flush_all overrides it.
module btb_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_jump,
    input  logic              flush_all
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0]       upd_cnt,
    output logic [31:0]       mispred_cnt
`endif
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              valid  [ENTRIES];
    logic [TAG_W-1:0]  tag    [ENTRIES];
    logic [ADDR_W-1:0] target [ENTRIES];
    logic [1:0]        ctr    [ENTRIES];

    logic [IDX_W-1:0]  l_idx;
    logic [TAG_W-1:0]  l_tag;
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    logic              eff_taken;
    logic              wr_en;
    logic [1:0]        nxt_ctr;
    logic [ADDR_W-1:0] nxt_target;

    // Instructions are word aligned, so the two low PC bits never select or tag an entry.
    logic unused_upd_pc_lsb;
    assign unused_upd_pc_lsb = ^upd_pc[1:0];

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];

    always_comb begin
        pred_hit    = valid[l_idx] && (tag[l_idx] == l_tag);
        pred_taken  = pred_hit && ctr[l_idx][1];
        pred_target = pred_taken ? target[l_idx] : lookup_pc + ADDR_W'(4);
    end

    always_comb begin
        u_hit      = valid[u_idx] && (tag[u_idx] == u_tag);
        eff_taken  = upd_taken | upd_jump;
        wr_en      = upd_valid && (u_hit || eff_taken);
        nxt_target = eff_taken ? upd_target : target[u_idx];
        nxt_ctr    = ctr[u_idx];
        if (upd_jump) begin
            nxt_ctr = 2'b11;
        end else if (u_hit) begin
            if (upd_taken && ctr[u_idx] != 2'b11)
                nxt_ctr = ctr[u_idx] + 2'd1;
            else if (!upd_taken && ctr[u_idx] != 2'b00)
                nxt_ctr = ctr[u_idx] - 2'd1;
        end else begin
            nxt_ctr = 2'b10;
        end
    end

    // Tag/target/ctr may still be written during a flush; they are hidden by the cleared valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else begin
            if (wr_en) begin
                tag[u_idx]    <= u_tag;
                target[u_idx] <= nxt_target;
                ctr[u_idx]    <= nxt_ctr;
            end
            if (flush_all) begin
                for (int i = 0; i < ENTRIES; i++)
                    valid[i] <= 1'b0;
            end else if (wr_en) begin
                valid[u_idx] <= 1'b1;
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic              p_taken;
    logic [ADDR_W-1:0] p_target;
    logic              mispred;

    // Re-derive what the predictor would have said for upd_pc before this update lands.
    always_comb begin
        p_taken  = u_hit && ctr[u_idx][1];
        p_target = p_taken ? target[u_idx] : upd_pc + ADDR_W'(4);
        mispred  = (p_taken != eff_taken) || (eff_taken && (p_target != upd_target));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_cnt     <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            upd_cnt <= upd_cnt + 32'd1;
            if (mispred)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed vector bench for btb_predictor (ENTRIES=16, ADDR_W=32).
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_jump;
    logic        flush_all;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] upd_cnt;
    logic [31:0] mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;

    btb_predictor #(.ADDR_W(32), .ENTRIES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_jump    (upd_jump),
        .flush_all   (flush_all)
`ifdef BTB_PERF_CNT_EN
        ,
        .upd_cnt     (upd_cnt),
        .mispred_cnt (mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        u;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
        logic        jp;
        logic        fl;
        logic [31:0] lk;
        logic        eh;
        logic        et;
        logic [31:0] eg;
    } vec_t;

    localparam int NV = 25;
    vec_t vec [NV];

    function automatic vec_t v(input logic u, input logic [31:0] pc, input logic tk,
                               input logic [31:0] tg, input logic jp, input logic fl,
                               input logic [31:0] lk, input logic eh, input logic et,
                               input logic [31:0] eg);
        vec_t r;
        r.u = u; r.pc = pc; r.tk = tk; r.tg = tg; r.jp = jp; r.fl = fl;
        r.lk = lk; r.eh = eh; r.et = et; r.eg = eg;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic eh, input logic et, input logic [31:0] eg);
        chk({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, eh});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, et});
        chk({tag, ".target"}, pred_target, eg);
    endtask

    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        upd_valid  = x.u;
        upd_pc     = x.pc;
        upd_taken  = x.tk;
        upd_target = x.tg;
        upd_jump   = x.jp;
        flush_all  = x.fl;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        upd_jump  = 1'b0;
        flush_all = 1'b0;
        lookup_pc = x.lk;
        #1;
        chk_pred(tag, x.eh, x.et, x.eg);
    endtask

    initial begin
        //            u  pc            tk  tg            jp fl lk            eh et eg
        vec[0]  = v(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       0, 0, 32'h44);
        vec[1]  = v(1, 32'h40,       1, 32'h100,      0, 0, 32'h40,       1, 1, 32'h100);
        vec[2]  = v(1, 32'h40,       0, 32'h0,        0, 0, 32'h40,       1, 0, 32'h44);
        vec[3]  = v(1, 32'h40,       0, 32'h0,        0, 0, 32'h40,       1, 0, 32'h44);
        vec[4]  = v(1, 32'h40,       0, 32'h0,        0, 0, 32'h40,       1, 0, 32'h44);
        vec[5]  = v(1, 32'h40,       1, 32'h140,      0, 0, 32'h40,       1, 0, 32'h44);
        vec[6]  = v(1, 32'h40,       1, 32'h180,      0, 0, 32'h40,       1, 1, 32'h180);
        vec[7]  = v(1, 32'h40,       1, 32'h180,      0, 0, 32'h40,       1, 1, 32'h180);
        vec[8]  = v(1, 32'h40,       1, 32'h180,      0, 0, 32'h40,       1, 1, 32'h180);
        vec[9]  = v(1, 32'h40,       0, 32'h0,        0, 0, 32'h40,       1, 1, 32'h180);
        vec[10] = v(1, 32'h80,       1, 32'h900,      0, 0, 32'h40,       0, 0, 32'h44);
        vec[11] = v(0, 32'h0,        0, 32'h0,        0, 0, 32'h80,       1, 1, 32'h900);
        vec[12] = v(1, 32'h84,       0, 32'h0,        0, 0, 32'h84,       0, 0, 32'h88);
        vec[13] = v(1, 32'h200,      0, 32'h3000,     1, 0, 32'h200,      1, 1, 32'h3000);
        vec[14] = v(1, 32'h200,      0, 32'h0,        0, 0, 32'h200,      1, 1, 32'h3000);
        vec[15] = v(1, 32'h200,      0, 32'h0,        0, 0, 32'h200,      1, 0, 32'h204);
        vec[16] = v(1, 32'h204,      1, 32'h500,      0, 0, 32'h204,      1, 1, 32'h500);
        vec[17] = v(0, 32'h204,      0, 32'h0,        0, 0, 32'h204,      1, 1, 32'h500);
        vec[18] = v(1, 32'h300,      1, 32'h700,      0, 1, 32'h300,      0, 0, 32'h304);
        vec[19] = v(0, 32'h0,        0, 32'h0,        0, 0, 32'h204,      0, 0, 32'h208);
        vec[20] = v(0, 32'h0,        0, 32'h0,        0, 0, 32'hFFFF_FFFC, 0, 0, 32'h0);
        vec[21] = v(1, 32'h8000_0040, 1, 32'hABC,     0, 0, 32'h8000_0040, 1, 1, 32'hABC);
        vec[22] = v(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       0, 0, 32'h44);
        vec[23] = v(1, 32'h4C,       1, 32'h1234,     0, 0, 32'h4D,       1, 1, 32'h1234);
        vec[24] = v(0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0040, 1, 1, 32'hABC);

        reset      = 1'b1;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        upd_jump   = 1'b0;
        flush_all  = 1'b0;
        lookup_pc  = 32'h40;
        #1;
        chk_pred("in_reset", 1'b0, 1'b0, 32'h44);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            apply(vec[i], $sformatf("vec%0d", i));

        // Same-cycle lookup sees pre-update contents; the change appears after the edge.
        @(negedge clk);
        lookup_pc  = 32'h8000_0040;
        upd_valid  = 1'b1;
        upd_pc     = 32'h8000_0040;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        #1;
        chk_pred("nobypass_pre", 1'b1, 1'b1, 32'hABC);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk_pred("nobypass_post", 1'b1, 1'b0, 32'h8000_0044);

        // Asynchronous reset mid-cycle with a pending allocating update.
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h111;
        #2;
        reset = 1'b1;
        #1;
        chk_pred("async_reset", 1'b0, 1'b0, 32'h8000_0044);
`ifdef BTB_PERF_CNT_EN
        chk("upd_cnt_rst", upd_cnt, 32'h0);
        chk("mispred_cnt_rst", mispred_cnt, 32'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        upd_valid = 1'b0;
        lookup_pc = 32'h40;
        #1;
        chk_pred("post_reset_40", 1'b0, 1'b0, 32'h44);
        lookup_pc = 32'h204;
        #1;
        chk_pred("post_reset_204", 1'b0, 1'b0, 32'h208);
`ifdef BTB_PERF_CNT_EN
        chk("upd_cnt_after", upd_cnt, 32'h0);
        chk("mispred_cnt_after", mispred_cnt, 32'h0);
`endif
        apply(v(1, 32'h40, 1, 32'h100, 0, 0, 32'h40, 1, 1, 32'h100), "realloc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
